// File: rtl/reg_bank_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_mp
// Description : Parametrised multi-port register bank with a per-entry
//               pending (busy) scoreboard for a pipelined RISC core.
//               Decode reads operands and marks destinations busy at issue.
//               Writeback writes results and clears the busy flags.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   i_rd_addr     NUM_RD packed read addresses   (port r = [r*ADDR_W +: ADDR_W])
//   o_rd_data     NUM_RD packed read data        (port r = [r*DATA_W +: DATA_W])
//   o_rd_busy     per read port: addressed entry has a pending producer
//   i_wr_en       per write port enable
//   i_wr_addr     NUM_WR packed write addresses
//   i_wr_data     NUM_WR packed write data
//   i_issue_en    mark i_issue_addr pending
//   i_issue_addr  destination of the issued instruction
//   o_wr_conflict registered: two or more enabled write ports hit the same
//                 address in the previous cycle
//
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
   output logic [NUM_RD-1:0]          o_rd_busy,
   input  logic [NUM_WR-1:0]          i_wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]   i_wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]   i_wr_data,
   input  logic                       i_issue_en,
   input  logic [ADDR_W-1:0]          i_issue_addr,
   output logic                       o_wr_conflict
);

   localparam int c_DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0]  r_mem [c_DEPTH];
   logic [c_DEPTH-1:0] r_pending;
   logic               r_conflict;

   logic [ADDR_W-1:0]  w_wr_addr [NUM_WR];
   logic [DATA_W-1:0]  w_wr_data [NUM_WR];
   logic [NUM_WR-1:0]  w_wr_keep;
   logic               w_conflict;
   logic [c_DEPTH-1:0] w_pend_next;
   logic               w_issue_keep;

   // Unpack write ports; a write is "kept" unless it targets the hardwired
   // zero entry, so dropped writes neither store, clear pending, nor conflict.
   for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
      assign w_wr_addr[p] = i_wr_addr[p*ADDR_W +: ADDR_W];
      assign w_wr_data[p] = i_wr_data[p*DATA_W +: DATA_W];
      assign w_wr_keep[p] = i_wr_en[p] &&
                            !((ZERO_REG != 0) && (w_wr_addr[p] == '0));
   end

   assign w_issue_keep = i_issue_en &&
                         !((ZERO_REG != 0) && (i_issue_addr == '0));

   // Any pair of kept write ports aiming at the same entry is a conflict.
   always_comb begin
      w_conflict = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
         for (int q = p + 1; q < NUM_WR; q++) begin
            if (w_wr_keep[p] && w_wr_keep[q] && (w_wr_addr[p] == w_wr_addr[q]))
               w_conflict = 1'b1;
         end
      end
   end

   // Writes clear first, then issue sets: a same-cycle issue to a written
   // entry leaves it pending because the new producer is still in flight.
   always_comb begin
      w_pend_next = r_pending;
      for (int p = 0; p < NUM_WR; p++) begin
         if (w_wr_keep[p])
            w_pend_next[w_wr_addr[p]] = 1'b0;
      end
      if (w_issue_keep)
         w_pend_next[i_issue_addr] = 1'b1;
   end

   // Ports are applied in ascending order so the highest-index port wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < c_DEPTH; i++)
            r_mem[i] <= '0;
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (w_wr_keep[p])
               r_mem[w_wr_addr[p]] <= w_wr_data[p];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending  <= '0;
         r_conflict <= 1'b0;
      end else begin
         r_pending  <= w_pend_next;
         r_conflict <= w_conflict;
      end
   end

   assign o_wr_conflict = r_conflict;

   // Read ports: zero entry overrides everything, then the same-cycle bypass
   // (highest-index matching write port), then the stored value.
   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_zero;
      logic              w_hit;
      logic [DATA_W-1:0] w_byp;

      assign w_ra   = i_rd_addr[r*ADDR_W +: ADDR_W];
      assign w_zero = (ZERO_REG != 0) && (w_ra == '0);

      always_comb begin
         w_hit = 1'b0;
         w_byp = '0;
         if ((BYPASS != 0) && !w_zero) begin
            for (int p = 0; p < NUM_WR; p++) begin
               if (i_wr_en[p] && (w_wr_addr[p] == w_ra)) begin
                  w_hit = 1'b1;
                  w_byp = w_wr_data[p];
               end
            end
         end
      end

      assign o_rd_data[r*DATA_W +: DATA_W] = w_zero ? '0 :
                                             (w_hit ? w_byp : r_mem[w_ra]);
      assign o_rd_busy[r] = r_pending[w_ra] & ~w_hit & ~w_zero;
   end

endmodule
`default_nettype wire
